// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
// Shared types and constants for the multicycle MIPS control path.
//   state_t      : 4-bit FSM state encoding (debug-visible on the state port)
//   aluop_t      : main-control to ALU-decoder operation class
//   OP_*         : instr[31:26] opcodes understood by the controller
//   FUNCT_*      : instr[5:0] function codes for R-type instructions
//   ALUCTL_*     : ALU operation codes driven on alucontrol
//   SRCB_*/PCSRC_: mux select encodings for ALU B input and next-PC source
//   FUNCT_TABLE / ALUCTL_TABLE : packed lookup used by the ALU decoder
// -----------------------------------------------------------------------------
package mips_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_ADDIEXEC = 4'd9,
        S_ADDIWB   = 4'd10,
        S_JUMP     = 4'd11   // only reachable when the jump feature is built in
    } state_t;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_t;

    // Opcodes
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    // R-type function codes
    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    // ALU operation codes
    localparam logic [2:0] ALUCTL_AND = 3'b000;
    localparam logic [2:0] ALUCTL_OR  = 3'b001;
    localparam logic [2:0] ALUCTL_ADD = 3'b010;
    localparam logic [2:0] ALUCTL_SUB = 3'b110;
    localparam logic [2:0] ALUCTL_SLT = 3'b111;

    // ALU B source select
    localparam logic [1:0] SRCB_RD2       = 2'b00;
    localparam logic [1:0] SRCB_FOUR      = 2'b01;
    localparam logic [1:0] SRCB_IMM       = 2'b10;
    localparam logic [1:0] SRCB_IMM_SHIFT = 2'b11;

    // Next-PC source select
    localparam logic [1:0] PCSRC_ALURESULT = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT    = 2'b01;
    localparam logic [1:0] PCSRC_JUMP      = 2'b10;

    // Funct -> ALU control lookup; entry i lives at bits [i*W +: W].
    // Codes are unique, so at most one entry can match a given funct.
    localparam int NUM_FUNCT = 5;
    localparam logic [NUM_FUNCT*6-1:0] FUNCT_TABLE =
        {FUNCT_SLT, FUNCT_OR, FUNCT_AND, FUNCT_SUB, FUNCT_ADD};
    localparam logic [NUM_FUNCT*3-1:0] ALUCTL_TABLE =
        {ALUCTL_SLT, ALUCTL_OR, ALUCTL_AND, ALUCTL_SUB, ALUCTL_ADD};

endpackage

// File: rtl/alu_decoder.sv
// -----------------------------------------------------------------------------
// alu_decoder
// Combinational ALU control decode.
//   aluop      in  2  operation class from the main FSM
//   funct      in  6  instr[5:0], consulted only for ALUOP_FUNCT
//   alucontrol out 3  ALU operation
// Unknown function codes fall back to add.
// -----------------------------------------------------------------------------
module alu_decoder
    import mips_pkg::*;
(
    input  aluop_t     aluop,
    input  logic [5:0] funct,
    output logic [2:0] alucontrol
);

    logic [NUM_FUNCT-1:0] funct_hit;
    logic [2:0]           funct_ctl [NUM_FUNCT];
    logic [2:0]           rtype_ctl;

    // One comparator per table entry; a matching entry contributes its code,
    // all others contribute zero so the results can simply be OR-ed together.
    generate
        for (genvar gi = 0; gi < NUM_FUNCT; gi++) begin : g_funct
            assign funct_hit[gi] = (funct == FUNCT_TABLE[gi*6 +: 6]);
            assign funct_ctl[gi] = funct_hit[gi] ? ALUCTL_TABLE[gi*3 +: 3] : 3'b000;
        end
    endgenerate

    always_comb begin
        rtype_ctl = 3'b000;
        for (int i = 0; i < NUM_FUNCT; i++) begin
            rtype_ctl = rtype_ctl | funct_ctl[i];
        end
        if (funct_hit == '0) begin
            rtype_ctl = ALUCTL_ADD;
        end
    end

    always_comb begin
        alucontrol = ALUCTL_ADD;
        case (aluop)
            ALUOP_ADD:   alucontrol = ALUCTL_ADD;
            ALUOP_SUB:   alucontrol = ALUCTL_SUB;
            ALUOP_FUNCT: alucontrol = rtype_ctl;
            default:     alucontrol = ALUCTL_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// -----------------------------------------------------------------------------
// multicycle_control
// Moore-style main controller for a multicycle MIPS subset
// (lw, sw, R-type, beq, addi, optionally j) sharing one memory port.
//
// Ports
//   clk, reset     : clock and synchronous active-high reset
//   op, funct      : instruction fields from the instruction register
//   zero           : ALU zero flag (beq condition)
//   mem_ready      : memory access completes this cycle
//   pcen           : PC enable = pcwrite | (branch & zero)
//   iord, irwrite, memwrite, memtoreg, regdst, regwrite, alusrca : datapath controls
//   alusrcb, pcsrc : datapath mux selects
//   alucontrol     : ALU operation from alu_decoder
//   state          : current state, for debug
//
// Build option
//   MULTICYCLE_JUMP_EN : when defined, op 000010 is executed through the JUMP
//                        state; when undefined it is treated as illegal.
//
// While reset is high the outputs show FETCH values with every write enable
// masked, so nothing in the datapath can be disturbed during reset even when
// reset arrives in the middle of an instruction.
// -----------------------------------------------------------------------------
module multicycle_control
    import mips_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pcen,
    output logic       iord,
    output logic       irwrite,
    output logic       memwrite,
    output logic       memtoreg,
    output logic       regdst,
    output logic       regwrite,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [2:0] alucontrol,
    output logic [1:0] pcsrc,
    output logic [3:0] state
);

    state_t state_reg;
    state_t state_next;
    aluop_t aluop;
    logic   pcwrite;
    logic   branch;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= S_FETCH;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        pcwrite    = 1'b0;
        branch     = 1'b0;
        iord       = 1'b0;
        irwrite    = 1'b0;
        memwrite   = 1'b0;
        memtoreg   = 1'b0;
        regdst     = 1'b0;
        regwrite   = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = SRCB_RD2;
        aluop      = ALUOP_ADD;
        pcsrc      = PCSRC_ALURESULT;

        case (state_reg)
            S_FETCH: begin
                // PC+4 is computed every cycle but only committed, together
                // with the instruction load, once memory returns the word.
                alusrcb = SRCB_FOUR;
                irwrite = mem_ready;
                pcwrite = mem_ready;
                if (mem_ready) begin
                    state_next = S_DECODE;
                end
            end
            S_DECODE: begin
                // Speculatively form the branch target into ALUOut.
                alusrcb = SRCB_IMM_SHIFT;
                case (op)
                    OP_LW, OP_SW: state_next = S_MEMADR;
                    OP_RTYPE:     state_next = S_EXECUTE;
                    OP_BEQ:       state_next = S_BRANCH;
                    OP_ADDI:      state_next = S_ADDIEXEC;
`ifdef MULTICYCLE_JUMP_EN
                    OP_J:         state_next = S_JUMP;
`endif
                    default:      state_next = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                alusrca    = 1'b1;
                alusrcb    = SRCB_IMM;
                state_next = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                iord = 1'b1;
                if (mem_ready) begin
                    state_next = S_MEMWB;
                end
            end
            S_MEMWB: begin
                memtoreg   = 1'b1;
                regwrite   = 1'b1;
                state_next = S_FETCH;
            end
            S_MEMWRITE: begin
                // The strobe is held until the memory accepts it; leaving on
                // the mem_ready cycle drops it in the following cycle.
                iord     = 1'b1;
                memwrite = 1'b1;
                if (mem_ready) begin
                    state_next = S_FETCH;
                end
            end
            S_EXECUTE: begin
                alusrca    = 1'b1;
                aluop      = ALUOP_FUNCT;
                state_next = S_ALUWB;
            end
            S_ALUWB: begin
                regdst     = 1'b1;
                regwrite   = 1'b1;
                state_next = S_FETCH;
            end
            S_BRANCH: begin
                alusrca    = 1'b1;
                aluop      = ALUOP_SUB;
                pcsrc      = PCSRC_ALUOUT;
                branch     = 1'b1;
                state_next = S_FETCH;
            end
            S_ADDIEXEC: begin
                alusrca    = 1'b1;
                alusrcb    = SRCB_IMM;
                state_next = S_ADDIWB;
            end
            S_ADDIWB: begin
                regwrite   = 1'b1;
                state_next = S_FETCH;
            end
`ifdef MULTICYCLE_JUMP_EN
            S_JUMP: begin
                pcsrc      = PCSRC_JUMP;
                pcwrite    = 1'b1;
                state_next = S_FETCH;
            end
`endif
            default: begin
                state_next = S_FETCH;
            end
        endcase

        // Reset overrides whatever state the register currently holds:
        // present FETCH selects with all enables low.
        if (reset) begin
            pcwrite  = 1'b0;
            branch   = 1'b0;
            iord     = 1'b0;
            irwrite  = 1'b0;
            memwrite = 1'b0;
            memtoreg = 1'b0;
            regdst   = 1'b0;
            regwrite = 1'b0;
            alusrca  = 1'b0;
            alusrcb  = SRCB_FOUR;
            aluop    = ALUOP_ADD;
            pcsrc    = PCSRC_ALURESULT;
        end

        pcen  = pcwrite | (branch & zero);
        state = reset ? S_FETCH : state_reg;
    end

    alu_decoder u_alu_decoder (
        .aluop      (aluop),
        .funct      (funct),
        .alucontrol (alucontrol)
    );

endmodule

// File: tb/tb_multicycle_control.sv
// -----------------------------------------------------------------------------
// tb_multicycle_control
// Scoreboard bench: the stimulus process walks each instruction through the
// phase sequence implied by its class, pushing the expected output word for
// every cycle; a monitor on the falling edge pops and compares.
// Honour MULTICYCLE_JUMP_EN identically to the design build.
// -----------------------------------------------------------------------------
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       pcen, iord, irwrite, memwrite, memtoreg, regdst, regwrite, alusrca;
    logic [1:0] alusrcb;
    logic [2:0] alucontrol;
    logic [1:0] pcsrc;
    logic [3:0] state;

    always #5 clk = ~clk;

    multicycle_control dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct      (funct),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .pcen       (pcen),
        .iord       (iord),
        .irwrite    (irwrite),
        .memwrite   (memwrite),
        .memtoreg   (memtoreg),
        .regdst     (regdst),
        .regwrite   (regwrite),
        .alusrca    (alusrca),
        .alusrcb    (alusrcb),
        .alucontrol (alucontrol),
        .pcsrc      (pcsrc),
        .state      (state)
    );

    // Phase codes as seen on the debug port
    localparam logic [3:0] P_FETCH = 4'd0,  P_DECODE = 4'd1,  P_MEMADR = 4'd2,
                           P_MEMREAD = 4'd3, P_MEMWB = 4'd4, P_MEMWRITE = 4'd5,
                           P_EXECUTE = 4'd6, P_ALUWB = 4'd7, P_BRANCH = 4'd8,
                           P_ADDIEXEC = 4'd9, P_ADDIWB = 4'd10, P_JUMP = 4'd11;

    localparam logic [5:0] I_RTYPE = 6'b000000, I_LW = 6'b100011, I_SW = 6'b101011,
                           I_BEQ = 6'b000100, I_ADDI = 6'b001000, I_J = 6'b000010;

    typedef struct packed {
        logic [3:0] st;
        logic       pcen, iord, irwrite, memwrite, memtoreg, regdst, regwrite, alusrca;
        logic [1:0] alusrcb;
        logic [2:0] aluctl;
        logic [1:0] pcsrc;
    } obs_t;

    obs_t  exp_q[$];
    string tag_q[$];
    int    checks = 0;
    int    errors = 0;

    function automatic logic [2:0] ref_alu(input logic [5:0] f);
        case (f)
            6'b100000: return 3'b010;
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b010;
        endcase
    endfunction

    // Expected outputs for one cycle spent in phase ph.
    function automatic obs_t expect_of(input logic [3:0] ph, input logic mr,
                                       input logic z, input logic rst,
                                       input logic [5:0] f);
        obs_t e;
        e = '0;
        e.aluctl = 3'b010;
        if (rst) begin
            e.st      = P_FETCH;
            e.alusrcb = 2'b01;
            return e;
        end
        e.st = ph;
        case (ph)
            P_FETCH:    begin e.alusrcb = 2'b01; e.irwrite = mr; e.pcen = mr; end
            P_DECODE:   e.alusrcb = 2'b11;
            P_MEMADR:   begin e.alusrca = 1'b1; e.alusrcb = 2'b10; end
            P_MEMREAD:  e.iord = 1'b1;
            P_MEMWB:    begin e.memtoreg = 1'b1; e.regwrite = 1'b1; end
            P_MEMWRITE: begin e.iord = 1'b1; e.memwrite = 1'b1; end
            P_EXECUTE:  begin e.alusrca = 1'b1; e.aluctl = ref_alu(f); end
            P_ALUWB:    begin e.regdst = 1'b1; e.regwrite = 1'b1; end
            P_BRANCH:   begin e.alusrca = 1'b1; e.aluctl = 3'b110; e.pcsrc = 2'b01; e.pcen = z; end
            P_ADDIEXEC: begin e.alusrca = 1'b1; e.alusrcb = 2'b10; end
            P_ADDIWB:   e.regwrite = 1'b1;
            P_JUMP:     begin e.pcsrc = 2'b10; e.pcen = 1'b1; end
            default:    ;
        endcase
        return e;
    endfunction

    // One clock cycle: drive inputs shortly after the edge, queue expectation.
    task automatic cyc(input logic [3:0] ph, input logic mr, input logic z,
                       input logic rst, input logic [5:0] o, input logic [5:0] f,
                       input string tag);
        @(posedge clk);
        #1;
        reset     = rst;
        mem_ready = mr;
        zero      = z;
        op        = o;
        funct     = f;
        exp_q.push_back(expect_of(ph, mr, z, rst, f));
        tag_q.push_back(tag);
    endtask

    task automatic plain(input logic [3:0] ph, input logic [5:0] o, input logic [5:0] f,
                         input string tag, inout int n);
        cyc(ph, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, o, f, tag);
        n++;
    endtask

    // nwait cycles with mem_ready low, then the completing cycle.
    task automatic mem_phase(input logic [3:0] ph, input int nwait, input logic [5:0] o,
                             input logic [5:0] f, input string tag, inout int n);
        for (int i = 0; i < nwait; i++) begin
            cyc(ph, 1'b0, 1'($urandom_range(0, 1)), 1'b0, o, f, tag);
            n++;
        end
        cyc(ph, 1'b1, 1'($urandom_range(0, 1)), 1'b0, o, f, tag);
        n++;
    endtask

    task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input int wf,
                             input int wm, input logic zb, input string tag);
        int n;
        n = 0;
        mem_phase(P_FETCH, wf, o, f, {tag, "/fetch"}, n);
        plain(P_DECODE, o, f, {tag, "/decode"}, n);
        case (o)
            I_LW: begin
                plain(P_MEMADR, o, f, {tag, "/memadr"}, n);
                mem_phase(P_MEMREAD, wm, o, f, {tag, "/memread"}, n);
                plain(P_MEMWB, o, f, {tag, "/memwb"}, n);
            end
            I_SW: begin
                plain(P_MEMADR, o, f, {tag, "/memadr"}, n);
                mem_phase(P_MEMWRITE, wm, o, f, {tag, "/memwrite"}, n);
            end
            I_RTYPE: begin
                plain(P_EXECUTE, o, f, {tag, "/execute"}, n);
                plain(P_ALUWB, o, f, {tag, "/aluwb"}, n);
            end
            I_BEQ: begin
                cyc(P_BRANCH, 1'($urandom_range(0, 1)), zb, 1'b0, o, f, {tag, "/branch"});
                n++;
            end
            I_ADDI: begin
                plain(P_ADDIEXEC, o, f, {tag, "/addiexec"}, n);
                plain(P_ADDIWB, o, f, {tag, "/addiwb"}, n);
            end
`ifdef MULTICYCLE_JUMP_EN
            I_J: plain(P_JUMP, o, f, {tag, "/jump"}, n);
`endif
            default: ;
        endcase
        $display("instr %s op=%b funct=%b cycles=%0d", tag, o, f, n);
    endtask

    // Monitor / scoreboard
    obs_t  mon_exp;
    obs_t  mon_act;
    string mon_tag;
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            mon_exp = exp_q.pop_front();
            mon_tag = tag_q.pop_front();
            mon_act = {state, pcen, iord, irwrite, memwrite, memtoreg, regdst, regwrite,
                       alusrca, alusrcb, alucontrol, pcsrc};
            checks++;
            if (mon_act !== mon_exp) begin
                errors++;
                $display("FAIL %s: got %b required %b (st|pcen,iord,irw,memw,m2r,rdst,rw,srca|srcb|aluctl|pcsrc)",
                         mon_tag, mon_act, mon_exp);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        logic [5:0] o;
        logic [5:0] f;
        logic [5:0] functs [6];
        functs[0] = 6'b100000; functs[1] = 6'b100010; functs[2] = 6'b100100;
        functs[3] = 6'b100101; functs[4] = 6'b101010; functs[5] = 6'b011011;

        reset = 1'b1; op = '0; funct = '0; zero = 1'b0; mem_ready = 1'b0;

        // Reset state, with mem_ready high to show write enables are masked
        for (int i = 0; i < 3; i++) cyc(P_FETCH, 1'b1, 1'b1, 1'b1, 6'd0, 6'd0, "reset");

        // lw, no wait states: 5 cycles
        run_instr(I_LW, 6'd0, 0, 0, 1'b0, "lw");
        // sw with mem_ready low for 3 cycles in MEMWRITE: memwrite for 4 cycles
        run_instr(I_SW, 6'd0, 0, 3, 1'b0, "sw_wait3");
        // R-type slt
        run_instr(I_RTYPE, 6'b101010, 0, 0, 1'b0, "slt");
        // beq taken / not taken
        run_instr(I_BEQ, 6'd0, 0, 0, 1'b1, "beq_z1");
        run_instr(I_BEQ, 6'd0, 0, 0, 1'b0, "beq_z0");
        // jump opcode (executed or treated as illegal depending on build)
        run_instr(I_J, 6'd0, 0, 0, 1'b0, "j");
        // illegal opcode
        run_instr(6'b111111, 6'd0, 0, 0, 1'b0, "illegal");
        // addi with a fetch wait
        run_instr(I_ADDI, 6'd0, 2, 0, 1'b0, "addi_fwait2");

        // reset for two cycles in the middle of a store
        n = 0;
        mem_phase(P_FETCH, 0, I_SW, 6'd0, "sw_rst/fetch", n);
        plain(P_DECODE, I_SW, 6'd0, "sw_rst/decode", n);
        plain(P_MEMADR, I_SW, 6'd0, "sw_rst/memadr", n);
        cyc(P_MEMWRITE, 1'b0, 1'b0, 1'b0, I_SW, 6'd0, "sw_rst/memwrite");
        cyc(P_FETCH, 1'b1, 1'b1, 1'b1, I_SW, 6'd0, "sw_rst/reset1");
        cyc(P_FETCH, 1'b1, 1'b1, 1'b1, I_SW, 6'd0, "sw_rst/reset2");
        $display("instr sw_rst interrupted by reset after %0d cycles", n + 1);
        run_instr(I_ADDI, 6'd0, 0, 0, 1'b0, "after_reset");

        // Randomized instruction stream
        for (int k = 0; k < 200; k++) begin
            case ($urandom_range(0, 6))
                0: o = I_LW;
                1: o = I_SW;
                2: o = I_RTYPE;
                3: o = I_BEQ;
                4: o = I_ADDI;
                5: o = I_J;
                default: begin
                    o = 6'($urandom_range(0, 63));
                    if (o == I_LW || o == I_SW || o == I_RTYPE || o == I_BEQ ||
                        o == I_ADDI || o == I_J) o = 6'b111111;
                end
            endcase
            f = functs[$urandom_range(0, 5)];
            run_instr(o, f, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                      1'($urandom_range(0, 1)), "rand");
        end

        @(negedge clk);
        @(negedge clk);
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard: %0d expectations left unchecked", exp_q.size());
        end
        if (checks < 500) begin
            errors++;
            $display("FAIL coverage: only %0d checks performed", checks);
        end
        if (errors == 0) begin
            $display("PASS Simulation finished: %0d checks, %0d errors", checks, errors);
        end else begin
            $display("FAIL Simulation finished: %0d checks, %0d errors", checks, errors);
        end
        $finish;
    end

endmodule
